step_ctrl_unit: RTL and testbench

STEP_CTRL_UNIT -- requirements
Module: step_ctrl_unit

---
 rtl/step_ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_step_ctrl_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl_unit.sv
// rtl/step_ctrl_unit.sv - phase-strobe control unit for a five-phase instruction sequencer
// Optional phase-order checking is compiled in when STEP_SEQ_CHECK_EN is defined.
module step_ctrl_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  step,
  input  logic [31:0] instr_in,
  output logic [31:0] ir_out,
  output logic        ir_load,
  output logic        alu_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        pc_inc,
  output logic [15:0] retired_cnt,
  output logic        seq_err
);

  localparam logic [4:0] PH_FETCH     = 5'd1;
  localparam logic [4:0] PH_DECODE    = 5'd2;
  localparam logic [4:0] PH_EXECUTE   = 5'd4;
  localparam logic [4:0] PH_MEMORY    = 5'd8;
  localparam logic [4:0] PH_WRITEBACK = 5'd16;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_NOP    = 3'd4
  } iclass_t;

  logic [4:0]  step_q;
  logic        step_onehot;
  logic        entry;
  iclass_t     cls_q;
  iclass_t     cls_d;
  logic [31:0] ir_d;
  logic [15:0] cnt_d;
  logic        ir_load_d;
  logic        alu_en_d;
  logic        mem_rd_d;
  logic        mem_wr_d;
  logic        reg_wr_d;
  logic        pc_inc_d;

  function automatic iclass_t decode_class(input logic [5:0] op);
    case (op)
      6'h00:   return CLS_ALU;
      6'h01:   return CLS_LOAD;
      6'h02:   return CLS_STORE;
      6'h03:   return CLS_BRANCH;
      default: return CLS_NOP;
    endcase
  endfunction

  // An entry is a change to a legal phase code; a held phase never re-fires.
  assign step_onehot = (step != 5'd0) && ((step & (step - 5'd1)) == 5'd0);
  assign entry       = step_onehot && (step != step_q);

  always_comb begin
    ir_d      = ir_out;
    cls_d     = cls_q;
    cnt_d     = retired_cnt;
    ir_load_d = 1'b0;
    alu_en_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    reg_wr_d  = 1'b0;
    pc_inc_d  = 1'b0;
    if (entry) begin
      case (step)
        PH_FETCH: begin
          ir_d      = instr_in;
          ir_load_d = 1'b1;
        end
        PH_DECODE: begin
          cls_d = decode_class(ir_out[31:26]);
        end
        PH_EXECUTE: begin
          alu_en_d = (cls_q != CLS_NOP);
        end
        PH_MEMORY: begin
          mem_rd_d = (cls_q == CLS_LOAD);
          mem_wr_d = (cls_q == CLS_STORE);
        end
        PH_WRITEBACK: begin
          reg_wr_d = (cls_q == CLS_ALU) || (cls_q == CLS_LOAD);
          pc_inc_d = 1'b1;
          cnt_d    = retired_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q      <= 5'd0;
      ir_out      <= 32'd0;
      cls_q       <= CLS_NOP;
      retired_cnt <= 16'd0;
      ir_load     <= 1'b0;
      alu_en      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      reg_wr      <= 1'b0;
      pc_inc      <= 1'b0;
    end else begin
      step_q      <= step;
      ir_out      <= ir_d;
      cls_q       <= cls_d;
      retired_cnt <= cnt_d;
      ir_load     <= ir_load_d;
      alu_en      <= alu_en_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      reg_wr      <= reg_wr_d;
      pc_inc      <= pc_inc_d;
    end
  end

`ifdef STEP_SEQ_CHECK_EN
  logic [4:0] last_phase;
  logic [4:0] expected_next;
  logic       seq_err_d;

  // A zero last_phase means nothing seen since reset, so any first phase is accepted.
  assign expected_next = (last_phase == PH_WRITEBACK) ? PH_FETCH : {last_phase[3:0], 1'b0};

  always_comb begin
    seq_err_d = seq_err;
    if (entry && (last_phase != 5'd0) && (step != expected_next))
      seq_err_d = 1'b1;
    if (!step_onehot && (step != 5'd0))
      seq_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_phase <= 5'd0;
      seq_err    <= 1'b0;
    end else begin
      seq_err <= seq_err_d;
      if (entry)
        last_phase <= step;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_step_ctrl_unit.sv
// tb/tb_step_ctrl_unit.sv - randomized and directed bench for step_ctrl_unit against a phase-rule model
module tb_step_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  step = 5'd0;
  logic [31:0] instr_in = 32'd0;
  logic [31:0] ir_out;
  logic        ir_load, alu_en, mem_rd, mem_wr, reg_wr, pc_inc, seq_err;
  logic [15:0] retired_cnt;

  step_ctrl_unit dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .instr_in    (instr_in),
    .ir_out      (ir_out),
    .ir_load     (ir_load),
    .alu_en      (alu_en),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .reg_wr      (reg_wr),
    .pc_inc      (pc_inc),
    .retired_cnt (retired_cnt),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

`ifdef STEP_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: class 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 NOP.
  logic [4:0]  m_prev;
  logic [31:0] m_ir;
  int          m_cls;
  logic [15:0] m_cnt;
  bit          m_err;
  int          m_last;
  logic [6:0]  m_strb;

  int t_ir, t_alu, t_rd, t_wr, t_reg, t_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 5'd0;
    m_ir   = 32'd0;
    m_cls  = 4;
    m_cnt  = 16'd0;
    m_err  = 1'b0;
    m_last = 0;
    m_strb = 7'd0;
  endtask

  task automatic model_edge();
    int  s;
    int  ones;
    bit  is_entry;
    if (reset) begin
      model_reset();
      return;
    end
    s        = int'(step);
    ones     = $countones(step);
    is_entry = (ones == 1) && (step != m_prev);
    m_strb   = 7'd0;
    if (is_entry) begin
      if (s == 1) begin
        m_ir      = instr_in;
        m_strb[6] = 1'b1;
      end else if (s == 2) begin
        m_cls = (m_ir[31:26] < 6'd4) ? int'(m_ir[31:26]) : 4;
      end else if (s == 4) begin
        m_strb[5] = (m_cls != 4);
      end else if (s == 8) begin
        m_strb[4] = (m_cls == 1);
        m_strb[3] = (m_cls == 2);
      end else begin
        m_strb[2] = (m_cls == 0) || (m_cls == 1);
        m_strb[1] = 1'b1;
        m_cnt     = m_cnt + 16'd1;
      end
      if (SEQ_ON && m_last != 0 && s != ((m_last == 16) ? 1 : m_last * 2))
        m_err = 1'b1;
      m_last = s;
    end
    if (SEQ_ON && ones > 1)
      m_err = 1'b1;
    m_strb[0] = m_err;
    m_prev    = step;
  endtask

  task automatic compare_all();
    check("strobes", 64'({ir_load, alu_en, mem_rd, mem_wr, reg_wr, pc_inc, seq_err}), 64'(m_strb));
    check("ir_out", 64'(ir_out), 64'(m_ir));
    check("retired_cnt", 64'(retired_cnt), 64'(m_cnt));
    check("one_phase",
          64'(($countones({ir_load, alu_en, mem_rd | mem_wr, reg_wr | pc_inc}) > 1) || (mem_rd && mem_wr)),
          64'(0));
  endtask

  task automatic clear_tally();
    t_ir = 0; t_alu = 0; t_rd = 0; t_wr = 0; t_reg = 0; t_pc = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    t_ir  += int'(ir_load);
    t_alu += int'(alu_en);
    t_rd  += int'(mem_rd);
    t_wr  += int'(mem_wr);
    t_reg += int'(reg_wr);
    t_pc  += int'(pc_inc);
  endtask

  task automatic hold(input logic [4:0] s, input int n);
    step = s;
    repeat (n) cycle();
  endtask

  task automatic run_seq(input logic [31:0] instr);
    instr_in = instr;
    for (int i = 0; i < 5; i++) hold(5'(1 << i), 2);
  endtask

  task automatic apply_reset();
    step  = 5'd0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle();
    reset = 1'b0;
  endtask

  task automatic check_tally(input string tag, input int ir, input int alu, input int rd,
                             input int wr, input int rg, input int pc);
    check({tag, "_ir_load"}, 64'(t_ir), 64'(ir));
    check({tag, "_alu_en"}, 64'(t_alu), 64'(alu));
    check({tag, "_mem_rd"}, 64'(t_rd), 64'(rd));
    check({tag, "_mem_wr"}, 64'(t_wr), 64'(wr));
    check({tag, "_reg_wr"}, 64'(t_reg), 64'(rg));
    check({tag, "_pc_inc"}, 64'(t_pc), 64'(pc));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 7);
    w[31:26] = (k < 4) ? 6'(k) : 6'($urandom_range(0, 63));
    return w;
  endfunction

  initial begin
    int          r;
    logic [4:0]  ph;

    model_reset();
    #1;
    compare_all();
    cycle();
    cycle();
    reset = 1'b0;

    clear_tally();
    run_seq(32'h0000_0000);
    check_tally("alu", 1, 1, 0, 0, 1, 1);
    check("alu_retired", 64'(retired_cnt), 64'(1));

    apply_reset();
    clear_tally();
    run_seq(32'h0400_0000);
    check_tally("load", 1, 1, 1, 0, 1, 1);
    clear_tally();
    run_seq(32'h0800_0000);
    check_tally("store", 1, 1, 0, 1, 0, 1);
    check("ls_retired", 64'(retired_cnt), 64'(2));

    clear_tally();
    run_seq(32'hFC00_0000);
    check_tally("nop", 1, 0, 0, 0, 0, 1);

    clear_tally();
    hold(5'd16, 6);
    check("held_wb_pc_inc", 64'(t_pc), 64'(0));

    apply_reset();
    instr_in = 32'h0000_0000;
    hold(5'd1, 2);
    hold(5'd2, 2);
    step = 5'd8;
    cycle();
    check("seq_err_skip", 64'(seq_err), 64'(SEQ_ON));
    cycle();
    hold(5'd16, 2);
    hold(5'd1, 2);
    check("seq_err_sticky", 64'(seq_err), 64'(SEQ_ON));
    clear_tally();
    hold(5'd3, 2);
    check_tally("bad_step", 0, 0, 0, 0, 0, 0);
    check("seq_err_bad", 64'(seq_err), 64'(SEQ_ON));

    apply_reset();
    instr_in = 32'h0400_0000;
    hold(5'd1, 2);
    hold(5'd2, 2);
    hold(5'd4, 2);
    step = 5'd8;
    cycle();
    check("mem_rd_before_reset", 64'(mem_rd), 64'(1));
    reset = 1'b1;
    #1;
    model_reset();
    check("mem_rd_at_reset", 64'(mem_rd), 64'(0));
    check("ir_out_at_reset", 64'(ir_out), 64'(0));
    check("cnt_at_reset", 64'(retired_cnt), 64'(0));
    cycle();
    step  = 5'd1;
    reset = 1'b0;
    cycle();
    check("ir_load_after_reset", 64'(ir_load), 64'(1));
    cycle();

    apply_reset();
    run_seq(32'h0000_0000);
    force dut.retired_cnt = 16'hFFFE;
    #1;
    release dut.retired_cnt;
    m_cnt = 16'hFFFE;
    check("preload", 64'(retired_cnt), 64'(16'hFFFE));
    run_seq(32'h0000_0000);
    check("cnt_ffff", 64'(retired_cnt), 64'(16'hFFFF));
    run_seq(32'h0000_0000);
    check("cnt_wrap", 64'(retired_cnt), 64'(0));

    apply_reset();
    ph = 5'd16;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 80) begin
        ph   = (ph == 5'd16) ? 5'd1 : {ph[3:0], 1'b0};
        step = ph;
      end else if (r < 88) begin
        ph   = 5'(1 << $urandom_range(0, 4));
        step = ph;
      end else if (r < 96) begin
        step = 5'($urandom_range(0, 31));
      end else begin
        apply_reset();
        continue;
      end
      repeat ($urandom_range(2, 3)) begin
        instr_in = rand_instr();
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
